lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Downstream consumer of the memory-mapped LCD register produced by the output buffer. It converts each software-issued LCD command or character into a correctly timed HD44780-style parallel write cycle: setup, enable pulse, hold, then execution wait. It exposes busy/done status for readback through the input buffer path, and holds one pending request while a cycle is in flight.

## Interface
Parameters:
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises.
- EN_CYC, 12: EN high width in cycles.
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls.
- WAIT_CYC, 2000: execution wait after a normal command or character.
- LONG_WAIT_CYC, 82000: execution wait after clear/home (RS=0, DATA[7:2]==0).

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lcd_reg  in  32  LCD register value; [31] ON, [10] request toggle, [9] RS, [7:0] DATA; other bits ignored.
- i_clr_ovr  in  1  one-cycle pulse clears o_overrun.
- o_busy  out  1  high while any cycle, init, or pending request is outstanding.
- o_done_tgl  out  1  toggles once per completed transfer.
- o_overrun  out  1  sticky; a request was lost.
- o_lcd_on  out  1  registered copy of i_lcd_reg[31].
- o_lcd_rs  out  1  LCD RS.
- o_lcd_rw  out  1  LCD RW, constant 0 (write-only).
- o_lcd_en  out  1  LCD enable strobe.
- o_lcd_data  out  8  LCD data bus.

## Operation
- Request detection: internal last_tgl register, reset 0. A request is accepted when i_lcd_reg[10] != last_tgl. On acceptance, last_tgl <= i_lcd_reg[10], and {RS, DATA} are captured into the pending slot.
- Pending slot: 1 deep. If a request arrives while the slot is full, the new request overwrites the slot and o_overrun is set. i_clr_ovr clears o_overrun, but a simultaneous overrun event wins.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT, plus INIT when the macro is enabled.
  - IDLE -> SETUP when the slot is full. The slot is moved into the output registers (o_lcd_rs/o_lcd_data) and emptied on the same edge.
  - SETUP (SETUP_CYC) -> PULSE.
  - PULSE (EN_CYC, o_lcd_en=1) -> HOLD.
  - HOLD (EN_CYC reused? no: HOLD_CYC) -> WAIT.
  - WAIT (LONG_WAIT_CYC if the latched command is clear/home, else WAIT_CYC) -> IDLE. o_done_tgl flips on this transition.
- A request accepted during any non-IDLE state fills the slot and is served immediately after WAIT; no IDLE dwell beyond 1 cycle.
- o_lcd_rs/o_lcd_data hold their last values in IDLE.
- o_busy = (state != IDLE) | slot_full.
- A single down-counter serves all states. Its width is $clog2 of the largest parameter + 1; it loads (N-1) on state entry and the state exits when it reaches 0. A parameter of 0 is illegal; a value of 1 gives a 1-cycle state.

## Timing
- Reset values: all outputs 0; state IDLE (or INIT); slot empty; counter 0.
- Reset assertion mid-cycle: o_lcd_en drops asynchronously, and the in-flight and pending requests are discarded.
- Latency: toggle change at edge k -> slot full after edge k -> SETUP entered at edge k+1 -> EN rises at edge k+1+SETUP_CYC -> EN high for exactly EN_CYC cycles.
- Total cycle length from SETUP entry to IDLE = SETUP_CYC+EN_CYC+HOLD_CYC+wait.
- o_lcd_on lags i_lcd_reg[31] by 1 cycle and is independent of the FSM.

## Configuration
- LCD_INIT_EN defined: after reset the FSM starts in INIT and autonomously issues 0x38, 0x0C, 0x01, 0x06 (RS=0) using the normal SETUP/PULSE/HOLD/WAIT timing. 0x01 uses LONG_WAIT_CYC. o_busy=1 throughout; o_done_tgl does not toggle for init commands. Requests arriving during INIT fill the slot and are served afterwards.
- LCD_INIT_EN undefined: the FSM starts in IDLE and software performs initialisation.

## Structure
- Shared package holds the state enum typedef, the register bit-position constants (ON=31, TGL=10, RS=9, DATA=7:0), and the init command ROM constant.
- One natural sub-module, lcd_timer: a loadable down-counter with a zero flag, instantiated once.

## Test plan
Parameters for the bench: SETUP=2, EN=4, HOLD=2, WAIT=10, LONG=40; LCD_INIT_EN undefined unless stated.
- Single write: i_lcd_reg={tgl=1,RS=1,DATA=0x41} -> RS=1, DATA=0x41 two cycles before EN; EN high 4 cycles; o_busy high 18+1 cycles; o_done_tgl 0->1.
- Clear command: DATA=0x01, RS=0 -> WAIT lasts 40 cycles; total busy 48+1 cycles.
- Back-to-back: a second toggle (DATA=0x42) during PULSE of the first -> second SETUP starts the cycle after the first WAIT ends; o_done_tgl toggles twice; o_overrun stays 0.
- Overrun: three toggles (0x41, 0x42, 0x43) while the first is in flight -> 0x41 then 0x43 emitted, o_overrun=1; i_clr_ovr pulse -> 0.
- Reset mid-PULSE: drive i_rst_n low -> o_lcd_en=0 in the same cycle, all outputs 0; after release no transfer occurs until the toggle changes.
- LCD_INIT_EN defined: reset release -> four EN pulses with DATA 0x38, 0x0C, 0x01, 0x06; o_done_tgl stays 0; a request issued during init is served fifth.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_ctrl_pkg
//  Description : Shared definitions for the HD44780-style LCD write
//                controller: FSM state type, LCD register bit positions,
//                power-on init command ROM and command classification.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_INIT  = 3'd5
    } lcd_state_t;

    // Bit positions inside the memory-mapped LCD register
    localparam int c_BIT_ON   = 31;
    localparam int c_BIT_TGL  = 10;
    localparam int c_BIT_RS   = 9;
    localparam int c_DATA_MSB = 7;
    localparam int c_DATA_LSB = 0;

    // Init sequence, issued in order from byte 0:
    // function set 8-bit/2-line, display on, clear, entry mode increment
    localparam int          c_INIT_CNT = 4;
    localparam logic [31:0] c_INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        return c_INIT_ROM[{idx, 3'b000} +: 8];
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_timer
//  Description : Loadable down-counter with zero flag. Loading takes priority;
//                otherwise the count decrements and stops at zero.
//  Ports       : i_clk, i_rst_n (async active-low), i_load, i_load_val,
//                o_zero (count is zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_ctrl
//  Description : Turns software LCD register writes into HD44780-style
//                parallel write cycles (setup, EN pulse, hold, execution
//                wait) with a one-deep pending request slot.
//  Config      : LCD_INIT_EN - when defined, the controller autonomously
//                issues the init sequence 0x38, 0x0C, 0x01, 0x06 after reset.
//  Ports       : i_clk, i_rst_n (async active-low)
//                i_lcd_reg  [31] ON, [10] request toggle, [9] RS, [7:0] DATA
//                i_clr_ovr  clears the sticky overrun flag
//                o_busy, o_done_tgl, o_overrun, o_lcd_on    status
//                o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data   LCD bus
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 12,
    parameter int HOLD_CYC      = 2,
    parameter int WAIT_CYC      = 2000,
    parameter int LONG_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_reg,
    input  logic        i_clr_ovr,
    output logic        o_busy,
    output logic        o_done_tgl,
    output logic        o_overrun,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data
);

    // One counter serves every state, so size it for the longest duration
    localparam int c_MAX_A = (SETUP_CYC > EN_CYC)   ? SETUP_CYC : EN_CYC;
    localparam int c_MAX_B = (c_MAX_A > HOLD_CYC)   ? c_MAX_A   : HOLD_CYC;
    localparam int c_MAX_C = (c_MAX_B > WAIT_CYC)   ? c_MAX_B   : WAIT_CYC;
    localparam int c_MAX   = (c_MAX_C > LONG_WAIT_CYC) ? c_MAX_C : LONG_WAIT_CYC;
    localparam int c_CNT_W = $clog2(c_MAX) + 1;

    // A state lasting N cycles loads N-1 on entry and exits on zero
    localparam logic [c_CNT_W-1:0] c_LD_SETUP = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_EN    = c_CNT_W'(EN_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_HOLD  = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_WAIT  = c_CNT_W'(WAIT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LD_LONG  = c_CNT_W'(LONG_WAIT_CYC - 1);
    localparam logic [1:0]         c_INIT_LAST = 2'(c_INIT_CNT - 1);

`ifdef LCD_INIT_EN
    localparam lcd_state_t c_RST_STATE = ST_INIT;
`else
    localparam lcd_state_t c_RST_STATE = ST_IDLE;
`endif

    lcd_state_t          r_state;
    lcd_state_t          w_state_nxt;
    logic                r_last_tgl;
    logic                r_slot_full;
    logic                r_slot_rs;
    logic [7:0]          r_slot_data;
    logic                r_lcd_rs;
    logic [7:0]          r_lcd_data;
    logic                r_lcd_en;
    logic                r_done_tgl;
    logic                r_overrun;
    logic                r_lcd_on;

    logic                w_req;
    logic                w_take;
    logic                w_launch_init;
    logic                w_finish;
    logic                w_load;
    logic [c_CNT_W-1:0]  w_load_val;
    logic                w_zero;
    logic                w_in_init;
    logic                w_init_more;
    logic [7:0]          w_init_cmd;
    logic                w_unused_bits;

    assign w_unused_bits = &{1'b0, i_lcd_reg[30:11], i_lcd_reg[8]};

    assign w_req = (i_lcd_reg[c_BIT_TGL] != r_last_tgl);

    lcd_timer #(
        .WIDTH      (c_CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

`ifdef LCD_INIT_EN
    logic       r_init_active;
    logic [1:0] r_init_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_active <= 1'b1;
            r_init_idx    <= 2'd0;
        end else if (w_finish && r_init_active) begin
            if (r_init_idx == c_INIT_LAST) begin
                r_init_active <= 1'b0;
            end else begin
                r_init_idx <= r_init_idx + 2'd1;
            end
        end
    end

    assign w_in_init   = r_init_active;
    assign w_init_more = r_init_active && (r_init_idx != c_INIT_LAST);
    assign w_init_cmd  = init_cmd(r_init_idx);
`else
    assign w_in_init   = 1'b0;
    assign w_init_more = 1'b0;
    assign w_init_cmd  = 8'h00;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_launch_init = 1'b0;
        w_finish      = 1'b0;
        w_load        = 1'b0;
        w_load_val    = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_slot_full) begin
                    w_state_nxt = ST_SETUP;
                    w_take      = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_SETUP;
                end
            end
            ST_INIT: begin
                w_state_nxt   = ST_SETUP;
                w_launch_init = 1'b1;
                w_load        = 1'b1;
                w_load_val    = c_LD_SETUP;
            end
            ST_SETUP: begin
                if (w_zero) begin
                    w_state_nxt = ST_PULSE;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_EN;
                end
            end
            ST_PULSE: begin
                if (w_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = c_LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_zero) begin
                    w_state_nxt = ST_WAIT;
                    w_load      = 1'b1;
                    // Classification uses the command already on the bus
                    w_load_val  = is_long_cmd(r_lcd_rs, r_lcd_data) ? c_LD_LONG : c_LD_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_zero) begin
                    w_finish    = 1'b1;
                    w_state_nxt = w_init_more ? ST_INIT : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= c_RST_STATE;
            r_last_tgl  <= 1'b0;
            r_slot_full <= 1'b0;
            r_slot_rs   <= 1'b0;
            r_slot_data <= 8'h00;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
            r_lcd_en    <= 1'b0;
            r_done_tgl  <= 1'b0;
            r_overrun   <= 1'b0;
            r_lcd_on    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lcd_on <= i_lcd_reg[c_BIT_ON];
            // EN is a registered decode of the next state so it is glitch-free
            r_lcd_en <= (w_state_nxt == ST_PULSE);

            // A new request always lands in the slot; a take on the same
            // edge has already moved the old contents out
            if (w_req) begin
                r_last_tgl  <= i_lcd_reg[c_BIT_TGL];
                r_slot_full <= 1'b1;
                r_slot_rs   <= i_lcd_reg[c_BIT_RS];
                r_slot_data <= i_lcd_reg[c_DATA_MSB:c_DATA_LSB];
            end else if (w_take) begin
                r_slot_full <= 1'b0;
            end

            if (w_take) begin
                r_lcd_rs   <= r_slot_rs;
                r_lcd_data <= r_slot_data;
            end else if (w_launch_init) begin
                r_lcd_rs   <= 1'b0;
                r_lcd_data <= w_init_cmd;
            end

            if (w_finish && !w_in_init) begin
                r_done_tgl <= ~r_done_tgl;
            end

            // Overwriting a still-pending request loses it; that beats a clear
            if (w_req && r_slot_full && !w_take) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_busy     = (r_state != ST_IDLE) | r_slot_full;
    assign o_done_tgl = r_done_tgl;
    assign o_overrun  = r_overrun;
    assign o_lcd_on   = r_lcd_on;
    assign o_lcd_rs   = r_lcd_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = r_lcd_en;
    assign o_lcd_data = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_ctrl
//  Description : Self-checking bench for lcd_ctrl. Requests are scheduled by
//                an arithmetic reference model (slot + free-time bookkeeping)
//                and compared with EN pulses captured on the LCD bus.
//  Config      : LCD_INIT_EN - also checks the autonomous init sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

    localparam int c_SETUP = 2;
    localparam int c_EN    = 4;
    localparam int c_HOLD  = 2;
    localparam int c_WAIT  = 10;
    localparam int c_LONG  = 40;

    typedef struct {
        int         t;
        logic       rs;
        logic [7:0] d;
    } req_t;

    typedef struct {
        int         rise;
        logic       rs;
        logic [7:0] d;
        int         width;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_lcd_reg = '0;
    logic        i_clr_ovr = 1'b0;
    logic        o_busy, o_done_tgl, o_overrun, o_lcd_on;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en;
    logic [7:0]  o_lcd_data;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     busy_cnt = 0;
    int     done_edges = 0;
    int     stab_bad = 0;
    logic   tgl_b = 1'b0;
    logic   on_b = 1'b0;
    logic   done_exp = 1'b0;
    logic   ovr_exp = 1'b0;
    req_t   reqs[$];
    pulse_t mon_q[$];
    pulse_t cur;
    logic   prev_en = 1'b0;
    logic   prev_done = 1'b0;
    logic [8:0] hist1 = '0;
    logic [8:0] hist2 = '0;

    lcd_ctrl #(
        .SETUP_CYC     (c_SETUP),
        .EN_CYC        (c_EN),
        .HOLD_CYC      (c_HOLD),
        .WAIT_CYC      (c_WAIT),
        .LONG_WAIT_CYC (c_LONG)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_lcd_reg  (i_lcd_reg),
        .i_clr_ovr  (i_clr_ovr),
        .o_busy     (o_busy),
        .o_done_tgl (o_done_tgl),
        .o_overrun  (o_overrun),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_data (o_lcd_data)
    );

    always #5 clk = ~clk;

    // Edge index: request driven before edge k is seen at edge k == cyc+1
    always @(posedge clk) cyc++;

    // Bus monitor: records each EN pulse and checks RS/DATA stability
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en   = 1'b0;
            prev_done = 1'b0;
            hist1     = '0;
            hist2     = '0;
        end else begin
            if (o_lcd_en) begin
                if (!prev_en) begin
                    cur.rise  = cyc;
                    cur.rs    = o_lcd_rs;
                    cur.d     = o_lcd_data;
                    cur.width = 0;
                    if ({o_lcd_rs, o_lcd_data} !== hist1 || {o_lcd_rs, o_lcd_data} !== hist2)
                        stab_bad++;
                end else if ({o_lcd_rs, o_lcd_data} !== {cur.rs, cur.d}) begin
                    stab_bad++;
                end
                cur.width++;
            end else if (prev_en) begin
                mon_q.push_back(cur);
            end
            if (o_busy) busy_cnt++;
            if (o_done_tgl !== prev_done) done_edges++;
            prev_done = o_done_tgl;
            prev_en   = o_lcd_en;
            hist2     = hist1;
            hist1     = {o_lcd_rs, o_lcd_data};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dur(input logic rs, input logic [7:0] d);
        return c_SETUP + c_EN + c_HOLD + (((!rs) && (d < 8'h04)) ? c_LONG : c_WAIT);
    endfunction

    // Called just after a negedge
    task automatic send(input logic rs, input logic [7:0] d);
        req_t r;
        tgl_b     = ~tgl_b;
        i_lcd_reg = {on_b, 20'($urandom), tgl_b, rs, 1'($urandom), d};
        r.t  = cyc + 1;
        r.rs = rs;
        r.d  = d;
        reqs.push_back(r);
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (o_lcd_en) ok = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (!o_busy) ok = 1'b1;
        end
    endtask

    // Reference schedule: a pending request starts one edge after both its
    // arrival and the previous transfer's return to idle
    task automatic check_batch(input string name);
        int     free_e;
        int     start;
        bit     pend;
        bit     ovr;
        req_t   p;
        pulse_t e;
        pulse_t exp_q[$];
        free_e = -1000;
        pend   = 1'b0;
        ovr    = 1'b0;
        foreach (reqs[i]) begin
            if (pend) begin
                start = ((p.t > free_e) ? p.t : free_e) + 1;
                if (start <= reqs[i].t) begin
                    e.rise = start + c_SETUP; e.rs = p.rs; e.d = p.d; e.width = c_EN;
                    exp_q.push_back(e);
                    free_e = start + dur(p.rs, p.d);
                    pend   = 1'b0;
                end else begin
                    ovr = 1'b1;
                end
            end
            p    = reqs[i];
            pend = 1'b1;
        end
        if (pend) begin
            start = ((p.t > free_e) ? p.t : free_e) + 1;
            e.rise = start + c_SETUP; e.rs = p.rs; e.d = p.d; e.width = c_EN;
            exp_q.push_back(e);
            free_e = start + dur(p.rs, p.d);
        end
        while (cyc < free_e + 2) @(negedge clk);
        chk({name, "_count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk({name, "_rise"},  mon_q[i].rise,  exp_q[i].rise);
            chk({name, "_rs"},    mon_q[i].rs,    exp_q[i].rs);
            chk({name, "_data"},  mon_q[i].d,     exp_q[i].d);
            chk({name, "_width"}, mon_q[i].width, exp_q[i].width);
        end
        ovr_exp  = ovr_exp | ovr;
        done_exp = done_exp ^ ((exp_q.size() % 2) == 1);
        chk({name, "_overrun"}, o_overrun, ovr_exp);
        chk({name, "_done"},    o_done_tgl, done_exp);
        chk({name, "_idle"},    o_busy, 1'b0);
        chk({name, "_stable"},  stab_bad, 0);
        reqs.delete();
        mon_q.delete();
    endtask

`ifdef LCD_INIT_EN
    task automatic init_phase();
        bit                ok;
        logic [7:0]        c_rom[4];
        c_rom[0] = 8'h38; c_rom[1] = 8'h0C; c_rom[2] = 8'h01; c_rom[3] = 8'h06;
        done_edges = 0;
        repeat (5) @(negedge clk);
        send(1'b1, 8'h55);
        wait_idle(ok);
        chk("init_idle", ok, 1'b1);
        chk("init_count", mon_q.size(), 5);
        for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
            chk("init_data",  mon_q[i].d,     c_rom[i]);
            chk("init_rs",    mon_q[i].rs,    1'b0);
            chk("init_width", mon_q[i].width, c_EN);
        end
        if (mon_q.size() > 4) begin
            chk("init_user_data", mon_q[4].d,  8'h55);
            chk("init_user_rs",   mon_q[4].rs, 1'b1);
        end
        chk("init_done_edges", done_edges, 1);
        done_exp = 1'b1;
        reqs.delete();
        mon_q.delete();
    endtask
`endif

    initial begin
        bit         ok;
        logic       rs;
        logic [7:0] d;
        int         n;

        // ---- reset state ----
        repeat (3) @(negedge clk);
`ifdef LCD_INIT_EN
        chk("rst_busy", o_busy, 1'b1);
`else
        chk("rst_busy", o_busy, 1'b0);
`endif
        chk("rst_done", o_done_tgl, 1'b0);
        chk("rst_ovr",  o_overrun, 1'b0);
        chk("rst_on",   o_lcd_on, 1'b0);
        chk("rst_rs",   o_lcd_rs, 1'b0);
        chk("rst_rw",   o_lcd_rw, 1'b0);
        chk("rst_en",   o_lcd_en, 1'b0);
        chk("rst_data", o_lcd_data, 8'h00);
        rst_n = 1'b1;
`ifdef LCD_INIT_EN
        init_phase();
`endif

        // ---- o_lcd_on lags the register by one cycle ----
        @(negedge clk);
        on_b = 1'b1;
        i_lcd_reg[31] = 1'b1;
        #1 chk("on_lag", o_lcd_on, 1'b0);
        @(negedge clk);
        chk("on_set", o_lcd_on, 1'b1);

        // ---- single character write ----
        @(negedge clk);
        busy_cnt = 0;
        send(1'b1, 8'h41);
        check_batch("single");
        chk("single_busy", busy_cnt, dur(1'b1, 8'h41) + 1);
        chk("single_rw", o_lcd_rw, 1'b0);

        // ---- clear display uses the long wait ----
        @(negedge clk);
        busy_cnt = 0;
        send(1'b0, 8'h01);
        check_batch("clear");
        chk("clear_busy", busy_cnt, dur(1'b0, 8'h01) + 1);

        // ---- back-to-back: second request during the first EN pulse ----
        @(negedge clk);
        send(1'b1, 8'h41);
        wait_en(ok);
        chk("b2b_en_seen", ok, 1'b1);
        send(1'b1, 8'h42);
        check_batch("b2b");

        // ---- overrun; clear on the same edge as the overrun loses ----
        @(negedge clk);
        send(1'b1, 8'h41);
        repeat (3) @(negedge clk);
        send(1'b1, 8'h42);
        repeat (2) @(negedge clk);
        i_clr_ovr = 1'b1;
        send(1'b1, 8'h43);
        @(negedge clk);
        i_clr_ovr = 1'b0;
        chk("ovr_wins_clr", o_overrun, 1'b1);
        check_batch("ovr");
        @(negedge clk);
        i_clr_ovr = 1'b1;
        @(negedge clk);
        i_clr_ovr = 1'b0;
        ovr_exp = 1'b0;
        chk("ovr_clr", o_overrun, 1'b0);

        // ---- randomized bursts ----
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(1, 25)) @(negedge clk);
                rs = 1'($urandom);
                d  = 8'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    rs = 1'b0;
                    d  = 8'($urandom_range(0, 3));
                end
                send(rs, d);
            end
            check_batch("rand");
            @(negedge clk);
            i_clr_ovr = 1'b1;
            @(negedge clk);
            i_clr_ovr = 1'b0;
            ovr_exp = 1'b0;
        end

        // ---- asynchronous reset in the middle of the EN pulse ----
        @(negedge clk);
        send(1'b1, 8'h5A);
        wait_en(ok);
        chk("mid_en_seen", ok, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n     = 1'b0;
        i_lcd_reg = '0;
        tgl_b     = 1'b0;
        on_b      = 1'b0;
        #1;
        chk("mid_rst_en",   o_lcd_en, 1'b0);
        chk("mid_rst_data", o_lcd_data, 8'h00);
        chk("mid_rst_rs",   o_lcd_rs, 1'b0);
        chk("mid_rst_done", o_done_tgl, 1'b0);
        chk("mid_rst_ovr",  o_overrun, 1'b0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        done_exp = 1'b0;
        ovr_exp  = 1'b0;
        reqs.delete();
        mon_q.delete();
`ifdef LCD_INIT_EN
        wait_idle(ok);
        chk("mid_reinit", ok, 1'b1);
        mon_q.delete();
`endif
        repeat (25) @(negedge clk);
        chk("post_rst_pulses", mon_q.size(), 0);
        chk("post_rst_busy",   o_busy, 1'b0);
        send(1'b1, 8'h33);
        check_batch("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
